// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one WIDTH-bit adder across N_REQ requesters, with chained carry
// Optional signed-overflow output resp_ovf is enabled by defining ADDER_ARB_OVF_EN.
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  input  logic [N_REQ-1:0]       req_chain,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [WIDTH-1:0]       resp_sum,
`ifdef ADDER_ARB_OVF_EN
  output logic                   resp_ovf,
`endif
  output logic                   resp_cout
);
  logic [IDW-1:0]   ptr_q, owner_q, id_q, gnt, idx, ptr_d;
  logic             lock_q, carry_q, vld_q, cout_q, vld_d;
  logic             free, acc, cin, cout;
  logic [WIDTH-1:0] sum_q, a_g, b_g, sum;
  always_comb begin
    idx = '0;
    gnt = owner_q;
    // descending scan so the nearest requester at or after ptr wins
    if (!lock_q)
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = IDW'((int'(ptr_q) + k) % N_REQ);
        if (req_valid[idx]) gnt = idx;
      end
  end
  assign free      = !vld_q || resp_ready;
  assign acc       = req_valid[gnt] && free && rst_n;
  assign req_ready = acc ? N_REQ'(1) << gnt : '0;
  assign a_g       = req_a[int'(gnt)*WIDTH +: WIDTH];
  assign b_g       = req_b[int'(gnt)*WIDTH +: WIDTH];
  assign cin       = lock_q ? carry_q : req_cin[gnt];
  assign {cout, sum} = {1'b0, a_g} + {1'b0, b_g} + {{WIDTH{1'b0}}, cin};
  assign ptr_d     = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);
  assign vld_d     = acc || (vld_q && !resp_ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (acc) begin
        id_q    <= gnt;
        sum_q   <= sum;
        cout_q  <= cout;
        carry_q <= cout;
        owner_q <= gnt;
        lock_q  <= req_chain[gnt];
        if (!req_chain[gnt]) ptr_q <= ptr_d;
      end
    end
  end
`ifdef ADDER_ARB_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (acc) ovf_q <= (a_g[WIDTH-1] == b_g[WIDTH-1]) && (sum[WIDTH-1] != a_g[WIDTH-1]);
  end
  assign resp_ovf = ovf_q;
`endif
  assign resp_valid = vld_q;
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = cout_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors with a queue scoreboard checked by an independent response monitor
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid, req_ready, req_cin, req_chain;
  logic [N*W-1:0] req_a, req_b;
  logic           resp_valid, resp_ready, resp_cout, resp_ovf;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_sum;
  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int n_cmp = 0;
  int n_err = 0;
  adder_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum),
`ifdef ADDER_ARB_OVF_EN
    .resp_ovf(resp_ovf),
`endif
    .resp_cout(resp_cout)
  );
`ifndef ADDER_ARB_OVF_EN
  assign resp_ovf = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input int id, input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.id = 2'(id);
    e.sum = s;
    e.cout = c;
    e.ovf = o;
    q.push_back(e);
  endtask
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic chain);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i] = cin;
    req_chain[i] = chain;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic rdy(input string nm, input logic [N-1:0] e);
    @(negedge clk);
    chk(nm, 64'(req_ready), 64'(e));
    step();
  endtask
  // monitor: every response handed over is matched against the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: id %0d sum %0h arrived with nothing expected", resp_id, resp_sum);
      end else begin
        me = q.pop_front();
        chk("sb_id", 64'(resp_id), 64'(me.id));
        chk("sb_sum", 64'(resp_sum), 64'(me.sum));
        chk("sb_cout", 64'(resp_cout), 64'(me.cout));
`ifdef ADDER_ARB_OVF_EN
        chk("sb_ovf", 64'(resp_ovf), 64'(me.ovf));
`endif
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_chain = '0; resp_ready = 1'b1;
    #2 rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_valid", 64'(resp_valid), 0);
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_sum", 64'(resp_sum), 0);
    chk("rst_cout", 64'(resp_cout), 0);
    chk("rst_id", 64'(resp_id), 0);
    @(negedge clk);
    #2 req_valid = '0;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_req(i, 32'(256 * (i + 1)), 32'(i), 1'b0, 1'b0);
    req_valid = '1;
    push(0, 32'h100, 0, 0); push(1, 32'h201, 0, 0); push(2, 32'h302, 0, 0);
    push(3, 32'h403, 0, 0); push(0, 32'h100, 0, 0);
    rdy("rr0", 4'b0001); rdy("rr1", 4'b0010); rdy("rr2", 4'b0100);
    rdy("rr3", 4'b1000); rdy("rr4", 4'b0001);
    req_valid = '0;
    step();
    set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    req_valid = 4'b0100;
    push(2, 32'h0, 1, 0);
    rdy("single", 4'b0100);
    chk("single_vld", 64'(resp_valid), 1);
    req_valid = '0;
    set_req(0, 32'h11, 32'h22, 1'b0, 1'b0);
    set_req(3, 32'h1000, 32'h1, 1'b0, 1'b0);
    req_valid = 4'b1001;
    push(3, 32'h1001, 0, 0); push(0, 32'h33, 0, 0);
    rdy("ptr_a", 4'b1000); rdy("ptr_b", 4'b0001);
    req_valid = '0;
    set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    set_req(0, 32'h5, 32'h6, 1'b0, 1'b0);
    req_valid = 4'b0011;
    push(1, 32'h0, 1, 0);
    rdy("ch_b1", 4'b0010);
    req_valid = 4'b0001;
    rdy("ch_gap0", 4'b0000); rdy("ch_gap1", 4'b0000);
    set_req(1, 32'h0, 32'h0, 1'b0, 1'b0);
    req_valid = 4'b0011;
    push(1, 32'h1, 0, 0);
    rdy("ch_b2", 4'b0010);
    req_valid = 4'b0001;
    push(0, 32'hB, 0, 0);
    rdy("ch_r0", 4'b0001);
    req_valid = '0;
    step();
    resp_ready = 1'b0;
    set_req(0, 32'h10, 32'h20, 1'b0, 1'b0);
    req_valid = 4'b0001;
    push(0, 32'h30, 0, 0);
    rdy("bp_acc", 4'b0001);
    set_req(0, 32'h40, 32'h1, 1'b0, 1'b0);
    push(0, 32'h41, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(req_ready), 0);
      chk("bp_sum", 64'(resp_sum), 64'h30);
      chk("bp_vld", 64'(resp_valid), 1);
      step();
    end
    resp_ready = 1'b1;
    rdy("bp_both", 4'b0001);
    chk("bp_vld_stay", 64'(resp_valid), 1);
    req_valid = '0;
    step();
    set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    req_valid = 4'b0100;
    rdy("rs_acc", 4'b0100);
    resp_ready = 1'b0;
    chk("rs_vld_pre", 64'(resp_valid), 1);
    chk("rs_cout_pre", 64'(resp_cout), 1);
    chk("rs_id_pre", 64'(resp_id), 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_vld", 64'(resp_valid), 0);
    chk("rs_cout", 64'(resp_cout), 0);
    chk("rs_id", 64'(resp_id), 0);
    chk("rs_sum", 64'(resp_sum), 0);
    chk("rs_ready", 64'(req_ready), 0);
    @(negedge clk);
    #2 req_valid = '0;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    step();
    set_req(2, 32'h5, 32'h7, 1'b0, 1'b0);
    req_valid = 4'b0100;
    push(2, 32'hC, 0, 0);
    rdy("rs_after", 4'b0100);
    set_req(3, 32'h5, 32'h7, 1'b1, 1'b0);
    req_valid = 4'b1000;
    push(3, 32'hD, 0, 0);
    rdy("cin1", 4'b1000);
    set_req(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    req_valid = 4'b0010;
    push(1, 32'h8000_0000, 0, 1);
    rdy("ovf_a", 4'b0010);
    set_req(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    push(1, 32'h0, 1, 1);
    rdy("ovf_b", 4'b0010);
    req_valid = '0;
    step(); step(); step();
    chk("sb_empty", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
